// File: rtl/router_fifo.sv
// rtl/router_fifo.sv - per-port packet buffer of the 1x3 router with header tagging and packet-length tracking
// Optional sticky error output err_flag is built when ROUTER_FIFO_ERR_FLAG_EN is defined.
module router_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              soft_reset,
    input  logic              write_enb,
    input  logic              read_enb,
    input  logic              lfd_state,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              full,
    output logic              empty,
    output logic              pkt_busy
`ifdef ROUTER_FIFO_ERR_FLAG_EN
    ,
    output logic              err_flag
`endif
);

    localparam int CNT_W = 6;

    logic [DATA_W:0]   mem [DEPTH];
    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              busy_q;
    logic              wr_fire;
    logic              rd_fire;
    logic [DATA_W:0]   rd_word;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                     (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    // full/empty are judged on the pre-edge pointers, so a write while full is
    // dropped even when a read frees a slot in the same cycle
    assign wr_fire = write_enb && !full  && !soft_reset;
    assign rd_fire = read_enb  && !empty && !soft_reset;
    assign rd_word = mem[rd_ptr_q[ADDR_W-1:0]];

    assign data_out = dout_q;
    assign pkt_busy = busy_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        dout_d   = dout_q;
        if (soft_reset) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            dout_d   = '0;
        end else begin
            if (wr_fire) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (rd_fire) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                dout_d   = rd_word[DATA_W-1:0];
                // header upper bits carry payload length; +1 accounts for the parity byte
                if (rd_word[DATA_W]) begin
                    count_d = rd_word[DATA_W-1 -: CNT_W] + 1'b1;
                end else if (count_q != '0) begin
                    count_d = count_q - 1'b1;
                end
            end else if (count_q == '0) begin
                dout_d = '0;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            busy_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            busy_q   <= (count_d != '0);
        end
    end

    // Storage is deliberately not cleared by either reset.
    always_ff @(posedge clock) begin
        if (wr_fire) begin
            mem[wr_ptr_q[ADDR_W-1:0]] <= {lfd_state, data_in};
        end
    end

`ifdef ROUTER_FIFO_ERR_FLAG_EN
    logic err_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            err_q <= 1'b0;
        end else if (soft_reset) begin
            err_q <= 1'b0;
        end else if ((write_enb && full) || (read_enb && empty && (count_q != '0))) begin
            err_q <= 1'b1;
        end
    end

    assign err_flag = err_q;
`endif

endmodule

// File: tb/tb_router_fifo.sv
// tb/tb_router_fifo.sv - directed and randomized bench for router_fifo against a queue-based packet model
module tb_router_fifo;

    logic       clock;
    logic       resetn;
    logic       soft_reset;
    logic       write_enb;
    logic       read_enb;
    logic       lfd_state;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       full;
    logic       empty;
    logic       pkt_busy;
`ifdef ROUTER_FIFO_ERR_FLAG_EN
    logic       err_flag;
`endif

    int checks = 0;
    int errors = 0;

    logic [8:0] q[$];
    int         m_cnt;
    logic [7:0] m_dout;
    bit         m_err;

    router_fifo #(.DEPTH(16), .ADDR_W(4), .DATA_W(8)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .soft_reset (soft_reset),
        .write_enb  (write_enb),
        .read_enb   (read_enb),
        .lfd_state  (lfd_state),
        .data_in    (data_in),
        .data_out   (data_out),
        .full       (full),
        .empty      (empty),
        .pkt_busy   (pkt_busy)
`ifdef ROUTER_FIFO_ERR_FLAG_EN
        ,
        .err_flag   (err_flag)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_cnt  = 0;
        m_dout = 8'h00;
        m_err  = 1'b0;
    endtask

    // One clock of stimulus; the model advances from the pre-edge occupancy.
    task automatic step(input logic we, input logic re, input logic lfd,
                        input logic [7:0] din, input logic sr);
        int         sz;
        bit         fm;
        bit         em;
        logic [8:0] w;
        write_enb  = we;
        read_enb   = re;
        lfd_state  = lfd;
        data_in    = din;
        soft_reset = sr;
        sz = q.size();
        fm = (sz == 16);
        em = (sz == 0);
        @(posedge clock);
        #1;
        if (sr) begin
            q.delete();
            m_cnt  = 0;
            m_dout = 8'h00;
            m_err  = 1'b0;
        end else begin
            if ((we && fm) || (re && em && m_cnt != 0)) m_err = 1'b1;
            if (re && !em) begin
                w = q.pop_front();
                m_dout = w[7:0];
                if (w[8]) m_cnt = int'(w[7:2]) + 1;
                else if (m_cnt != 0) m_cnt = m_cnt - 1;
            end else if (m_cnt == 0) begin
                m_dout = 8'h00;
            end
            if (we && !fm) q.push_back({lfd, din});
        end
        write_enb  = 1'b0;
        read_enb   = 1'b0;
        lfd_state  = 1'b0;
        soft_reset = 1'b0;
        chk("empty", empty, q.size() == 0);
        chk("full", full, q.size() == 16);
        chk("data_out", data_out, m_dout);
        chk("pkt_busy", pkt_busy, m_cnt != 0);
`ifdef ROUTER_FIFO_ERR_FLAG_EN
        chk("err_flag", err_flag, m_err);
`endif
    endtask

    task automatic wr(input logic lfd, input logic [7:0] din);
        step(1'b1, 1'b0, lfd, din, 1'b0);
    endtask

    task automatic rd();
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        logic [7:0] rt[5];
        logic [8:0] src[$];
        logic [8:0] w;
        int         cyc;
        bit         we;
        bit         re;
        bit         acc;

        rt = '{8'h0D, 8'hA1, 8'hA2, 8'hA3, 8'h0C};
        resetn = 1'b0; soft_reset = 1'b0; write_enb = 1'b0; read_enb = 1'b0;
        lfd_state = 1'b0; data_in = 8'h00;
        model_reset();
        #1;
        chk("rst_empty", empty, 1'b1);
        chk("rst_full", full, 1'b0);
        chk("rst_dout", data_out, 8'h00);
        chk("rst_busy", pkt_busy, 1'b0);
        repeat (2) @(posedge clock);
        #1 resetn = 1'b1;

        // full packet round trip
        for (int i = 0; i < 5; i++) wr(i == 0, rt[i]);
        for (int i = 0; i < 5; i++) begin
            rd();
            chk("rt_dout", data_out, rt[i]);
            chk("rt_busy", pkt_busy, i < 4);
        end
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("rt_idle_dout", data_out, 8'h00);

        // fill and overflow
        for (int i = 0; i < 16; i++) wr(1'b0, 8'(8'h10 + i));
        chk("fill_full", full, 1'b1);
        wr(1'b0, 8'hFF);
        chk("ovf_full", full, 1'b1);
        step(1'b1, 1'b1, 1'b0, 8'hEE, 1'b0);
        chk("full_rw_dout", data_out, 8'h10);
        chk("full_rw_full", full, 1'b0);
        for (int i = 1; i < 16; i++) begin
            rd();
            chk("drain_dout", data_out, 8'(8'h10 + i));
        end
        chk("drain_empty", empty, 1'b1);

        // read while empty
        rd();
        chk("empty_rd_dout", data_out, 8'h00);
        chk("empty_rd_empty", empty, 1'b1);
`ifdef ROUTER_FIFO_ERR_FLAG_EN
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        wr(1'b1, 8'h0D);
        rd();
        rd();
        chk("underflow_err", err_flag, 1'b1);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("err_cleared", err_flag, 1'b0);
`endif

        // soft reset mid-packet
        for (int i = 0; i < 5; i++) wr(i == 0, rt[i]);
        rd();
        rd();
        chk("sr_pre_dout", data_out, 8'hA1);
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
        chk("sr_empty", empty, 1'b1);
        chk("sr_busy", pkt_busy, 1'b0);
        chk("sr_dout", data_out, 8'h00);
        wr(1'b0, 8'h55);
        rd();
        chk("sr_after_dout", data_out, 8'h55);

        // 40 single-byte packets with random gaps, streamed across pointer wrap
        for (int i = 0; i < 40; i++) begin
            src.push_back({1'b1, 8'h00});
            src.push_back({1'b0, 8'($urandom)});
        end
        cyc = 0;
        while ((src.size() > 0 || q.size() > 0) && cyc < 2000) begin
            we  = (src.size() > 0) && ($urandom_range(0, 3) != 0);
            re  = ($urandom_range(0, 3) != 0);
            w   = (src.size() > 0) ? src[0] : 9'h000;
            acc = we && (q.size() < 16);
            step(we, re, w[8], w[7:0], 1'b0);
            if (acc) void'(src.pop_front());
            cyc++;
        end
        chk("wrap_remaining", src.size() + q.size(), 0);

        // async reset asserted in the middle of a write
        wr(1'b1, 8'h0D);
        wr(1'b0, 8'hB1);
        rd();
        chk("pre_rst_busy", pkt_busy, 1'b1);
        write_enb = 1'b1; lfd_state = 1'b0; data_in = 8'hC3;
        #2 resetn = 1'b0;
        #1;
        model_reset();
        chk("async_empty", empty, 1'b1);
        chk("async_full", full, 1'b0);
        chk("async_dout", data_out, 8'h00);
        chk("async_busy", pkt_busy, 1'b0);
        @(posedge clock);
        #1 resetn = 1'b1; write_enb = 1'b0;
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("post_rst_empty", empty, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/router_fifo.md
Name: router_fifo

Overview:
- Output-port packet buffer of the 1x3 router, one instance per destination port.
- Sits directly downstream of the register stage and captures its 8-bit dout when the FSM asserts the per-port write enable.
- Tags each byte with the first-byte (header) marker and tracks packet length on the read side, so the destination sees whole packets.
- Supports a per-port soft reset, issued by the synchroniser on a read timeout.

Parameters:
- DEPTH, 16, number of storage entries; must be a power of 2.
- ADDR_W, 4, log2(DEPTH).
- DATA_W, 8, payload byte width; the stored word is DATA_W+1 bits.

Ports:
- clock  in  1  system clock, all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- soft_reset  in  1  synchronous, active-high port flush.
- write_enb  in  1  write request.
- read_enb  in  1  read request from the destination.
- lfd_state  in  1  marks the current write as a header byte.
- data_in  in  DATA_W  byte from the register stage.
- data_out  out  DATA_W  registered read data.
- full  out  1  no free entry.
- empty  out  1  no stored entry.
- pkt_busy  out  1  read side is partway through a packet (count != 0).

Behaviour:
- Storage: mem[DEPTH], each entry {hdr, byte}, where hdr = lfd_state sampled at write time.
- Pointers: wr_ptr and rd_ptr, ADDR_W+1 bits each, wrap naturally modulo 2*DEPTH.
- empty = (wr_ptr == rd_ptr).
- full = MSBs differ AND low ADDR_W bits are equal.
- full and empty are combinational from the registered pointers.
- Write: if write_enb && !full, then mem[wr_ptr[ADDR_W-1:0]] <= {lfd_state, data_in} and wr_ptr++. A write while full is dropped and no state changes.
- Read: if read_enb && !empty, then data_out <= stored byte and rd_ptr++. Read latency is 1 cycle: data is valid the cycle after read_enb is sampled.
- Packet counter count[5:0] (6 bits), updated on each successful read:
  - Stored hdr=1: count <= byte[7:2] + 1 (payload length plus parity byte).
  - Stored hdr=0 and count != 0: count <= count - 1.
  - Stored hdr=0 and count == 0: count holds.
- pkt_busy = (count != 0), registered.
- data_out when no read occurs: holds its value while count != 0; driven to 0 when count == 0 (idle bus).
- Simultaneous read and write:
  - Not full and not empty: both succeed; occupancy is unchanged.
  - full: the read succeeds and the write is dropped, because full is evaluated before the read.
  - empty: the write succeeds and the read is ignored.
- soft_reset=1: wr_ptr, rd_ptr, count and data_out all go to 0 at the clock edge. Read and write in the same cycle are suppressed. mem contents are left as-is.
- resetn=0: immediately (asynchronously) sets wr_ptr=rd_ptr=0, count=0, data_out=0, so empty=1, full=0, pkt_busy=0. mem is not cleared.
- Reset released mid-operation: the block resumes empty on the next edge, and no partial packet state survives.
- Header with length 0: count is loaded with 1, so only the parity byte follows.

Optional Feature:
- Macro: ROUTER_FIFO_ERR_FLAG_EN.
- When defined: adds output port err_flag (1 bit, sticky). err_flag sets on either of:
  - a write attempt while full;
  - a read attempt while empty with count != 0 (underflow mid-packet).
- err_flag clears only on resetn or soft_reset.
- When not defined: the port and its logic are absent; drop/ignore behaviour is unchanged.

Test Plan:
- Reset check: assert resetn=0 mid-write -> empty=1, full=0, data_out=0x00 and pkt_busy=0 immediately, before any clock edge.
- Full packet round trip: write header 0x0D with lfd=1 (length 3), then 0xA1, 0xA2, 0xA3 and parity 0x0C; then read 5 cycles.
  - data_out shows 0x0D, A1, A2, A3, 0C on successive cycles.
  - count goes 4, 3, 2, 1, 0.
  - pkt_busy falls after the 5th read.
  - data_out = 0x00 on the next idle cycle.
- Fill and overflow: 16 writes -> full=1 after the 16th. A 17th write is dropped: a later readout returns only the first 16 bytes. A simultaneous read and write while full -> the read returns byte 0, the write is dropped, full=0 next cycle.
- Empty read: read_enb=1 with empty=1 -> rd_ptr unchanged, data_out stays 0x00, empty stays 1. With ROUTER_FIFO_ERR_FLAG_EN defined and count != 0 -> err_flag=1.
- Soft reset mid-packet: after 2 of 5 bytes are read, pulse soft_reset together with read_enb -> next cycle empty=1, pkt_busy=0, data_out=0x00, and no byte is consumed.
- Pointer wrap: stream 40 single-byte packets (header 0x00 + parity) with concurrent reads -> all data is returned in order across pointer wrap, and full is never falsely asserted.
